grid_square_object: RTL and testbench

- Parametrised successor to the single-rectangle bracket object.
- Describes a ROWS x COLS grid of equally sized cells, such as the invader formation. All cells share one top-left anchor and a fixed pitch.
- Keeps a per-cell alive mask with kill and revive commands and a live-cell counter.
- Latches the anchor position only at frame start, so the formation never tears mid-frame.
- Outputs the drawing request, the cell index and the offset inside the cell to the bitmap and collision logic. The VGA mux sits downstream.

---
 rtl/grid_square_object_if.sv | 34 +++
 rtl/grid_square_object.sv | 140 ++++++++++++++
 tb/tb_grid_square_object.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/grid_square_object_if.sv
// Pixel, anchor, kill and drawing-output signals shared between the grid object and its client.
interface grid_square_object_if;
  logic        startOfFrame;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic [10:0] topLeftX;
  logic [10:0] topLeftY;
  logic        killValid;
  logic [2:0]  killRow;
  logic [3:0]  killCol;
  logic        reviveAll;
  logic        drawingRequest;
  logic [7:0]  RGBout;
  logic [10:0] offsetX;
  logic [10:0] offsetY;
  logic [2:0]  hitRow;
  logic [3:0]  hitCol;
  logic [7:0]  aliveCount;
  logic        allDead;

  modport master (
    output startOfFrame, pixelX, pixelY, topLeftX, topLeftY,
           killValid, killRow, killCol, reviveAll,
    input  drawingRequest, RGBout, offsetX, offsetY, hitRow, hitCol,
           aliveCount, allDead
  );

  modport slave (
    input  startOfFrame, pixelX, pixelY, topLeftX, topLeftY,
           killValid, killRow, killCol, reviveAll,
    output drawingRequest, RGBout, offsetX, offsetY, hitRow, hitCol,
           aliveCount, allDead
  );
endinterface

// File: rtl/grid_square_object.sv
// ROWS x COLS grid of equal cells sharing one frame-latched anchor, with a per-cell alive mask.
// Produces registered drawing request, cell index and in-cell offsets one cycle after the pixel.
module grid_square_object #(
  parameter int unsigned ROWS         = 4,
  parameter int unsigned COLS         = 8,
  parameter int unsigned CELL_W       = 32,
  parameter int unsigned CELL_H       = 32,
  parameter int unsigned GAP_X        = 16,
  parameter int unsigned GAP_Y        = 16,
  parameter int unsigned INIT_X       = 100,
  parameter int unsigned INIT_Y       = 50,
  parameter logic [7:0]  OBJECT_COLOR = 8'h5b
) (
  input logic                 clk,
  input logic                 resetN,
  grid_square_object_if.slave bus
);

  localparam int unsigned PITCH_X = CELL_W + GAP_X;
  localparam int unsigned PITCH_Y = CELL_H + GAP_Y;
  localparam int unsigned GRID_W  = COLS * PITCH_X;
  localparam int unsigned GRID_H  = ROWS * PITCH_Y;
  localparam int unsigned N_CELLS = ROWS * COLS;
  localparam int unsigned IDX_W   = (N_CELLS > 1) ? $clog2(N_CELLS) : 1;

  logic [10:0]        anchor_x_q, anchor_x_d;
  logic [10:0]        anchor_y_q, anchor_y_d;
  logic [N_CELLS-1:0] alive_q, alive_d;
  logic [7:0]         alive_count_q, alive_count_d;
  logic               all_dead_q, all_dead_d;
  logic               draw_q, draw_d;
  logic [7:0]         rgb_q, rgb_d;
  logic [10:0]        offset_x_q, offset_x_d;
  logic [10:0]        offset_y_q, offset_y_d;
  logic [2:0]         hit_row_q, hit_row_d;
  logic [3:0]         hit_col_q, hit_col_d;

  logic [11:0]        dx, dy;
  int unsigned        dx_i, dy_i, col_i, row_i, lx_i, ly_i;
  logic               in_grid, in_cell;
  logic [IDX_W-1:0]   cell_idx, kill_idx;
  logic               kill_ok;

  // Anchor only moves at frame start so the formation never tears.
  always_comb begin
    anchor_x_d = anchor_x_q;
    anchor_y_d = anchor_y_q;
    if (bus.startOfFrame) begin
      anchor_x_d = bus.topLeftX;
      anchor_y_d = bus.topLeftY;
    end
  end

  // Geometry: 12-bit difference keeps the sign so anchors near the edge cannot wrap.
  always_comb begin
    dx       = {1'b0, bus.pixelX} - {1'b0, anchor_x_q};
    dy       = {1'b0, bus.pixelY} - {1'b0, anchor_y_q};
    dx_i     = 32'(dx[10:0]);
    dy_i     = 32'(dy[10:0]);
    in_grid  = !dx[11] && !dy[11] && (dx_i < GRID_W) && (dy_i < GRID_H);
    col_i    = dx_i / PITCH_X;
    row_i    = dy_i / PITCH_Y;
    lx_i     = dx_i - col_i * PITCH_X;
    ly_i     = dy_i - row_i * PITCH_Y;
    cell_idx = IDX_W'(row_i * COLS + col_i);
    in_cell  = in_grid && (lx_i < CELL_W) && (ly_i < CELL_H);
  end

  always_comb begin
    draw_d     = 1'b0;
    rgb_d      = 8'hFF;
    offset_x_d = 11'd0;
    offset_y_d = 11'd0;
    hit_row_d  = 3'd0;
    hit_col_d  = 4'd0;
    if (in_cell && alive_q[cell_idx]) begin
      draw_d     = 1'b1;
      rgb_d      = OBJECT_COLOR;
      offset_x_d = 11'(lx_i);
      offset_y_d = 11'(ly_i);
      hit_row_d  = 3'(row_i);
      hit_col_d  = 4'(col_i);
    end
  end

  // Alive mask and counter: revive has priority over kill; dead or out-of-range kills are dropped.
  always_comb begin
    kill_idx      = IDX_W'(32'(bus.killRow) * COLS + 32'(bus.killCol));
    kill_ok       = bus.killValid && (32'(bus.killRow) < ROWS) && (32'(bus.killCol) < COLS)
                    && alive_q[kill_idx] && (alive_count_q != 8'd0);
    alive_d       = alive_q;
    alive_count_d = alive_count_q;
    if (bus.reviveAll) begin
      alive_d       = '1;
      alive_count_d = 8'(N_CELLS);
    end else if (kill_ok) begin
      alive_d[kill_idx] = 1'b0;
      alive_count_d     = alive_count_q - 8'd1;
    end
    all_dead_d = (alive_count_q == 8'd0);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      anchor_x_q    <= 11'(INIT_X);
      anchor_y_q    <= 11'(INIT_Y);
      alive_q       <= '1;
      alive_count_q <= 8'(N_CELLS);
      all_dead_q    <= 1'b0;
      draw_q        <= 1'b0;
      rgb_q         <= 8'h00;
      offset_x_q    <= 11'd0;
      offset_y_q    <= 11'd0;
      hit_row_q     <= 3'd0;
      hit_col_q     <= 4'd0;
    end else begin
      anchor_x_q    <= anchor_x_d;
      anchor_y_q    <= anchor_y_d;
      alive_q       <= alive_d;
      alive_count_q <= alive_count_d;
      all_dead_q    <= all_dead_d;
      draw_q        <= draw_d;
      rgb_q         <= rgb_d;
      offset_x_q    <= offset_x_d;
      offset_y_q    <= offset_y_d;
      hit_row_q     <= hit_row_d;
      hit_col_q     <= hit_col_d;
    end
  end

  assign bus.drawingRequest = draw_q;
  assign bus.RGBout         = rgb_q;
  assign bus.offsetX        = offset_x_q;
  assign bus.offsetY        = offset_y_q;
  assign bus.hitRow         = hit_row_q;
  assign bus.hitCol         = hit_col_q;
  assign bus.aliveCount     = alive_count_q;
  assign bus.allDead        = all_dead_q;

endmodule

// File: tb/tb_grid_square_object.sv
// Directed bench for grid_square_object: anchor latch, cell geometry, kill/revive and async reset.
module tb_grid_square_object;
  logic clk;
  logic resetN;
  int   checks;
  int   errors;
  logic [37:0] got;

  grid_square_object_if bus ();

  grid_square_object dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view: draw, rgb, offsetX, offsetY, hitRow, hitCol
  function automatic logic [37:0] outs();
    return {bus.drawingRequest, bus.RGBout, bus.offsetX, bus.offsetY, bus.hitRow, bus.hitCol};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input int x, input int y);
    bus.pixelX = 11'(x);
    bus.pixelY = 11'(y);
    tick();
    got = outs();
  endtask

  task automatic set_anchor(input int x, input int y);
    bus.topLeftX     = 11'(x);
    bus.topLeftY     = 11'(y);
    bus.startOfFrame = 1'b1;
    tick();
    bus.startOfFrame = 1'b0;
  endtask

  task automatic kill(input int r, input int c);
    bus.killRow   = 3'(r);
    bus.killCol   = 4'(c);
    bus.killValid = 1'b1;
    tick();
    bus.killValid = 1'b0;
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    bus.startOfFrame = 1'b0;
    bus.pixelX = 11'd100; bus.pixelY = 11'd50;
    bus.topLeftX = 11'd100; bus.topLeftY = 11'd50;
    bus.killValid = 1'b0; bus.killRow = 3'd0; bus.killCol = 4'd0;
    bus.reviveAll = 1'b0;
    repeat (3) tick();
    got = outs();
    checks++;
    if (got !== 38'd0) begin
      errors++; $display("FAIL reset_outputs got %h exp %h", got, 38'd0);
    end
    checks++;
    if ({bus.aliveCount, bus.allDead} !== {8'd32, 1'b0}) begin
      errors++; $display("FAIL reset_count got %0d/%b exp 32/0", bus.aliveCount, bus.allDead);
    end
    #2 resetN = 1'b1;
    tick();
  endtask

  task automatic test_latch();
    set_anchor(100, 50);
    present(100, 50);
    checks++;
    if (got !== {1'b1, 8'h5b, 11'd0, 11'd0, 3'd0, 4'd0}) begin
      errors++; $display("FAIL latch_draw got %h exp %h", got, {1'b1, 8'h5b, 11'd0, 11'd0, 3'd0, 4'd0});
    end
  endtask

  task automatic test_geometry();
    present(132, 50);
    checks++;
    if (got !== {1'b0, 8'hFF, 29'd0}) begin
      errors++; $display("FAIL gap_x got %h exp %h", got, {1'b0, 8'hFF, 29'd0});
    end
    present(147, 81);
    checks++;
    if (got !== {1'b0, 8'hFF, 29'd0}) begin
      errors++; $display("FAIL gap_147_81 got %h exp %h", got, {1'b0, 8'hFF, 29'd0});
    end
    present(148, 98);
    checks++;
    if (got !== {1'b1, 8'h5b, 11'd0, 11'd0, 3'd1, 4'd1}) begin
      errors++; $display("FAIL cell_1_1 got %h exp %h", got, {1'b1, 8'h5b, 11'd0, 11'd0, 3'd1, 4'd1});
    end
    // dx=105 -> col 2 lx 9 ; dy=70 -> row 1 ly 22
    present(205, 120);
    checks++;
    if (got !== {1'b1, 8'h5b, 11'd9, 11'd22, 3'd1, 4'd2}) begin
      errors++; $display("FAIL cell_1_2 got %h exp %h", got, {1'b1, 8'h5b, 11'd9, 11'd22, 3'd1, 4'd2});
    end
    present(467, 225);
    checks++;
    if (got !== {1'b1, 8'h5b, 11'd31, 11'd31, 3'd3, 4'd7}) begin
      errors++; $display("FAIL last_cell_corner got %h exp %h", got, {1'b1, 8'h5b, 11'd31, 11'd31, 3'd3, 4'd7});
    end
    present(484, 50);
    checks++;
    if (got !== {1'b0, 8'hFF, 29'd0}) begin
      errors++; $display("FAIL past_grid got %h exp %h", got, {1'b0, 8'hFF, 29'd0});
    end
    present(99, 50);
    checks++;
    if (got !== {1'b0, 8'hFF, 29'd0}) begin
      errors++; $display("FAIL left_of_grid got %h exp %h", got, {1'b0, 8'hFF, 29'd0});
    end
  endtask

  task automatic test_midframe();
    bus.topLeftX = 11'd300;
    present(100, 50);
    checks++;
    if (got[37] !== 1'b1) begin
      errors++; $display("FAIL midframe_hold got %b exp 1", got[37]);
    end
    bus.startOfFrame = 1'b1;
    tick();
    bus.startOfFrame = 1'b0;
    present(100, 50);
    checks++;
    if (got !== {1'b0, 8'hFF, 29'd0}) begin
      errors++; $display("FAIL after_sof got %h exp %h", got, {1'b0, 8'hFF, 29'd0});
    end
    set_anchor(100, 50);
  endtask

  task automatic test_kill();
    kill(1, 1);
    present(148, 98);
    checks++;
    if ({got[37], bus.aliveCount} !== {1'b0, 8'd31}) begin
      errors++; $display("FAIL kill_1_1 got %b/%0d exp 0/31", got[37], bus.aliveCount);
    end
    kill(1, 1);
    checks++;
    if (bus.aliveCount !== 8'd31) begin
      errors++; $display("FAIL kill_repeat got %0d exp 31", bus.aliveCount);
    end
    kill(5, 0);
    kill(0, 8);
    checks++;
    if (bus.aliveCount !== 8'd31) begin
      errors++; $display("FAIL kill_out_of_range got %0d exp 31", bus.aliveCount);
    end
    present(100, 50);
    checks++;
    if (got[37] !== 1'b1) begin
      errors++; $display("FAIL neighbour_alive got %b exp 1", got[37]);
    end
  endtask

  task automatic test_kill_all_revive();
    bus.killValid = 1'b1;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 8; c++) begin
        bus.killRow = 3'(r);
        bus.killCol = 4'(c);
        tick();
      end
    end
    bus.killRow = 3'd0; bus.killCol = 4'd0;
    checks++;
    if ({bus.aliveCount, bus.allDead} !== {8'd0, 1'b0}) begin
      errors++; $display("FAIL kill_all_count got %0d/%b exp 0/0", bus.aliveCount, bus.allDead);
    end
    tick();
    checks++;
    if ({bus.aliveCount, bus.allDead} !== {8'd0, 1'b1}) begin
      errors++; $display("FAIL all_dead got %0d/%b exp 0/1", bus.aliveCount, bus.allDead);
    end
    bus.killValid = 1'b0;
    present(100, 50);
    checks++;
    if (got !== {1'b0, 8'hFF, 29'd0}) begin
      errors++; $display("FAIL dead_cell_draw got %h exp %h", got, {1'b0, 8'hFF, 29'd0});
    end
    bus.killValid = 1'b1; bus.reviveAll = 1'b1;
    tick();
    bus.killValid = 1'b0; bus.reviveAll = 1'b0;
    checks++;
    if (bus.aliveCount !== 8'd32) begin
      errors++; $display("FAIL revive_count got %0d exp 32", bus.aliveCount);
    end
    tick();
    checks++;
    if (bus.allDead !== 1'b0) begin
      errors++; $display("FAIL revive_alldead got %b exp 0", bus.allDead);
    end
    // A kill on the same cycle as the pixel does not hide that pixel.
    bus.killRow = 3'd0; bus.killCol = 4'd0; bus.killValid = 1'b1;
    present(100, 50);
    bus.killValid = 1'b0;
    checks++;
    if (got[37] !== 1'b1) begin
      errors++; $display("FAIL kill_same_cycle got %b exp 1", got[37]);
    end
    present(100, 50);
    checks++;
    if ({got[37], bus.aliveCount} !== {1'b0, 8'd31}) begin
      errors++; $display("FAIL kill_next_cycle got %b/%0d exp 0/31", got[37], bus.aliveCount);
    end
  endtask

  task automatic test_edge();
    set_anchor(0, 0);
    present(2047, 0);
    checks++;
    if (got !== {1'b0, 8'hFF, 29'd0}) begin
      errors++; $display("FAIL edge_2047 got %h exp %h", got, {1'b0, 8'hFF, 29'd0});
    end
    present(50, 0);
    checks++;
    if (got !== {1'b1, 8'h5b, 11'd2, 11'd0, 3'd0, 4'd1}) begin
      errors++; $display("FAIL edge_origin got %h exp %h", got, {1'b1, 8'h5b, 11'd2, 11'd0, 3'd0, 4'd1});
    end
    // Anchor at 2000: pixel 10 would alias to dx=58 (a live cell) if dx wrapped.
    set_anchor(2000, 0);
    present(10, 0);
    checks++;
    if (got !== {1'b0, 8'hFF, 29'd0}) begin
      errors++; $display("FAIL no_wrap got %h exp %h", got, {1'b0, 8'hFF, 29'd0});
    end
  endtask

  task automatic test_async_reset();
    set_anchor(100, 50);
    present(148, 98);
    checks++;
    if (got[37] !== 1'b1) begin
      errors++; $display("FAIL pre_reset_draw got %b exp 1", got[37]);
    end
    bus.topLeftX = 11'd300;
    #2 resetN = 1'b0;
    #1;
    got = outs();
    checks++;
    if ({got, bus.aliveCount, bus.allDead} !== {38'd0, 8'd32, 1'b0}) begin
      errors++; $display("FAIL async_reset got %h/%0d/%b exp 0/32/0", got, bus.aliveCount, bus.allDead);
    end
    #1 resetN = 1'b1;
    present(100, 50);
    checks++;
    if (got !== {1'b1, 8'h5b, 11'd0, 11'd0, 3'd0, 4'd0}) begin
      errors++; $display("FAIL reset_anchor got %h exp %h", got, {1'b1, 8'h5b, 11'd0, 11'd0, 3'd0, 4'd0});
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_latch();
    test_geometry();
    test_midframe();
    test_kill();
    test_kill_all_revive();
    test_edge();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
